// File: rtl/clint_timer_wb.sv
// Machine-timer block on Wishbone: a prescaled 64-bit mtime counter, NUM_CMP mtimecmp
// comparators with level interrupts, a shadow latch for atomic 64-bit reads, registered responses.
module clint_timer_wb #(
    parameter logic [31:0] BASE_ADR   = 32'h0000_2000,
    parameter int          NUM_CMP    = 2,
    parameter int          PRESCALE_W = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_stall_o,
    output logic [NUM_CMP-1:0] mtip_o
);

    localparam logic [31:0] END_OFF = 32'(16 + 8 * NUM_CMP);

    logic [63:0]           mtime_q, mtime_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  en_q, en_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [63:0]           cmp_q [NUM_CMP];
    logic [63:0]           cmp_d [NUM_CMP];
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_q, dat_d;

    logic [31:0] off;
    logic        accept;
    logic        bad;
    logic        wr;
    logic        rd;
    logic        tick;
    logic [31:0] rdata;
    logic [31:0] pre_w;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    assign off    = wb_adr_i - BASE_ADR;
    assign accept = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign bad    = (wb_adr_i < BASE_ADR) | (wb_adr_i[1:0] != 2'b00) | (off >= END_OFF);
    assign wr     = accept & ~bad & wb_we_i;
    assign rd     = accept & ~bad & ~wb_we_i;

    // Read mux sees only registered state, so a read coincident with a tick returns pre-tick mtime.
    always_comb begin
        rdata = '0;
        case (off)
            32'h00:  rdata = mtime_q[31:0];
            32'h04:  rdata = shadow_q;
            32'h08:  rdata = {31'b0, en_q};
            32'h0C:  rdata = 32'(prescale_q);
            default: begin
                for (int n = 0; n < NUM_CMP; n++) begin
                    if (off == 32'(16 + 8 * n)) rdata = cmp_q[n][31:0];
                    if (off == 32'(20 + 8 * n)) rdata = cmp_q[n][63:32];
                end
            end
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q;
        pcnt_d     = pcnt_q;
        prescale_d = prescale_q;
        en_d       = en_q;
        shadow_d   = shadow_q;
        cmp_d      = cmp_q;
        pre_w      = merge(32'(prescale_q), wb_dat_i, wb_sel_i);
        tick       = en_q && (pcnt_q == prescale_q);

        if (tick) begin
            pcnt_d  = '0;
            mtime_d = mtime_q + 64'd1;
        end else if (en_q) begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end

        if (rd && off == 32'h00) shadow_d = mtime_q[63:32];

        // A bus write to mtime overrides the increment, so that cycle never ticks.
        if (wr) begin
            case (off)
                32'h00: begin
                    mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wb_dat_i, wb_sel_i)};
                    pcnt_d  = '0;
                end
                32'h04: begin
                    mtime_d = {merge(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
                    pcnt_d  = '0;
                end
                32'h08: begin
                    if (wb_sel_i[0]) en_d = wb_dat_i[0];
                    pcnt_d = '0;
                end
                32'h0C: begin
                    prescale_d = pre_w[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                default: begin
                    for (int n = 0; n < NUM_CMP; n++) begin
                        if (off == 32'(16 + 8 * n))
                            cmp_d[n] = {cmp_q[n][63:32], merge(cmp_q[n][31:0], wb_dat_i, wb_sel_i)};
                        if (off == 32'(20 + 8 * n))
                            cmp_d[n] = {merge(cmp_q[n][63:32], wb_dat_i, wb_sel_i), cmp_q[n][31:0]};
                    end
                end
            endcase
        end

        ack_d = accept & ~bad;
        err_d = accept & bad;
        dat_d = rd ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mtime_q    <= '0;
            pcnt_q     <= '0;
            prescale_q <= '0;
            en_q       <= 1'b1;
            shadow_q   <= '0;
            for (int n = 0; n < NUM_CMP; n++) cmp_q[n] <= '1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            mtime_q    <= mtime_d;
            pcnt_q     <= pcnt_d;
            prescale_q <= prescale_d;
            en_q       <= en_d;
            shadow_q   <= shadow_d;
            cmp_q      <= cmp_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
        assign mtip_o[gi] = (mtime_q >= cmp_q[gi]);
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_clint_timer_wb.sv
// Bench for clint_timer_wb: directed scenarios plus random accesses, all checked against
// a transaction-level timer model held as one packed state record.
module tb_clint_timer_wb;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          NC   = 2;

    logic        clk, rst;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack_o, err_o, stall_o;
    logic [NC-1:0] mtip;

    int checks = 0;
    int errors = 0;

    clint_timer_wb #(.BASE_ADR(BASE), .NUM_CMP(NC), .PRESCALE_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_o),
        .wb_ack_o(ack_o), .wb_err_o(err_o), .wb_stall_o(stall_o), .mtip_o(mtip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]          tm;
        logic [31:0]          pcnt;
        logic                 en;
        logic [31:0]          pre;
        logic [NC-1:0][63:0]  cmp;
        logic [31:0]          shadow;
        logic                 ack;
        logic                 err;
        logic [31:0]          dat;
    } mstate_t;

    mstate_t ms;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r;
        r = '0;
        r.en = 1'b1;
        for (int n = 0; n < NC; n++) r.cmp[n] = '1;
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic c, input logic st, input logic w,
                                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        mstate_t r;
        logic [63:0] t0;
        logic [31:0] off;
        logic bad;
        int idx;
        r = s;
        t0 = s.tm;
        idx = 0;
        if (s.en) begin
            if (s.pcnt == s.pre) begin
                r.tm = s.tm + 64'd1;
                r.pcnt = 0;
            end else begin
                r.pcnt = s.pcnt + 1;
            end
        end
        r.ack = 1'b0;
        r.err = 1'b0;
        r.dat = '0;
        if (c && st && !s.ack && !s.err) begin
            off = a - BASE;
            bad = (a < BASE) || (a[1:0] != 2'b00) || (off >= 32'(16 + 8 * NC));
            if (off >= 32'd16) idx = int'((off - 32'd16) >> 3);
            if (bad) begin
                r.err = 1'b1;
            end else begin
                r.ack = 1'b1;
                if (!w) begin
                    case (off)
                        32'h00: begin r.dat = t0[31:0]; r.shadow = t0[63:32]; end
                        32'h04: r.dat = s.shadow;
                        32'h08: r.dat = {31'b0, s.en};
                        32'h0C: r.dat = s.pre;
                        default: r.dat = off[2] ? s.cmp[idx][63:32] : s.cmp[idx][31:0];
                    endcase
                end else begin
                    case (off)
                        32'h00: begin r.tm = {t0[63:32], bmerge(t0[31:0], d, sl)}; r.pcnt = 0; end
                        32'h04: begin r.tm = {bmerge(t0[63:32], d, sl), t0[31:0]}; r.pcnt = 0; end
                        32'h08: begin if (sl[0]) r.en = d[0]; r.pcnt = 0; end
                        32'h0C: begin r.pre = bmerge(s.pre, d, sl) & 32'hFF; r.pcnt = 0; end
                        default: begin
                            if (off[2]) r.cmp[idx][63:32] = bmerge(s.cmp[idx][63:32], d, sl);
                            else        r.cmp[idx][31:0]  = bmerge(s.cmp[idx][31:0], d, sl);
                        end
                    endcase
                end
            end
        end
        return r;
    endfunction

    function automatic logic [NC-1:0] model_mtip();
        logic [NC-1:0] e;
        for (int n = 0; n < NC; n++) e[n] = (ms.tm >= ms.cmp[n]);
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= model_reset();
        else     ms <= model_next(ms, cyc, stb, we, adr, wdat, sel);
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rdv, output logic ak, output logic er);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        rdv = dat_o; ak = ack_o; er = err_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("txn we=%0b adr=%h wdat=%h sel=%h -> ack=%0b err=%0b rdat=%h", w, a, d, s, ak, er, rdv);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r; logic ak, er;
        checks++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_resp got ack=%b err=%b exp 0 0", ack_o, err_o); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", dat_o); end
        checks++; if (mtip !== '0) begin errors++; $display("FAIL reset_mtip got %b exp 0", mtip); end
        idle(10);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'd10) begin errors++; $display("FAIL idle10_lo got %0d exp 10", r); end
        checks++; if (r !== ms.dat || ak !== 1'b1) begin errors++; $display("FAIL idle10_model got %h/%b exp %h/1", r, ak, ms.dat); end
        checks++; if (mtip !== '0) begin errors++; $display("FAIL idle10_mtip got %b exp 0", mtip); end
    endtask

    task automatic test_prescale();
        logic [31:0] a, b; logic ak, er;
        bus(1'b1, BASE + 32'hC, 32'd3, 4'hF, a, ak, er);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, a, ak, er);
        idle(39);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, b, ak, er);
        checks++; if (b - a !== 32'd10) begin errors++; $display("FAIL prescale3_delta got %0d exp 10", b - a); end
        checks++; if (b !== ms.dat) begin errors++; $display("FAIL prescale3_model got %h exp %h", b, ms.dat); end
        bus(1'b1, BASE + 32'h8, 32'h0, 4'h1, a, ak, er);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, a, ak, er);
        idle(19);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, b, ak, er);
        checks++; if (b !== a) begin errors++; $display("FAIL frozen got %h exp %h", b, a); end
        bus(1'b0, BASE + 32'h8, 32'h0, 4'hF, b, ak, er);
        checks++; if (b !== 32'h0) begin errors++; $display("FAIL ctrl_read got %h exp 0", b); end
    endtask

    task automatic test_carry();
        logic [31:0] r; logic ak, er;
        bus(1'b1, BASE + 32'hC, 32'd0, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h8, 32'd1, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h4, 32'd0, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h0, 32'hFFFF_FFFE, 4'hF, r, ak, er);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL carry_lo got %h exp ffffffff", r); end
        idle(5);
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL shadow_hi got %h exp 0", r); end
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== ms.dat) begin errors++; $display("FAIL carry_lo2 got %h exp %h", r, ms.dat); end
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL carry_hi got %h exp 1", r); end
    endtask

    task automatic test_compare();
        logic [31:0] r; logic ak, er;
        int rose;
        rose = 0;
        bus(1'b1, BASE + 32'h8, 32'd0, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h18, 32'd100, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h1C, 32'd0, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h0, 32'd0, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h4, 32'd0, 4'hF, r, ak, er);
        bus(1'b1, BASE + 32'h8, 32'd1, 4'hF, r, ak, er);
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            checks++; if (mtip !== model_mtip()) begin errors++; $display("FAIL cmp_track got %b exp %b at mtime %0d", mtip, model_mtip(), ms.tm); end
            if (mtip[1] === 1'b1 && rose == 0) begin
                rose = 1;
                checks++; if (ms.tm !== 64'd100) begin errors++; $display("FAIL cmp_rise_time got %0d exp 100", ms.tm); end
            end
        end
        checks++; if (rose != 1) begin errors++; $display("FAIL cmp_rise_timeout got %0d exp 1", rose); end
        checks++; if (mtip[0] !== 1'b0) begin errors++; $display("FAIL cmp0_quiet got %b exp 0", mtip[0]); end
        bus(1'b1, BASE + 32'h1C, 32'd1, 4'hF, r, ak, er);
        checks++; if (mtip[1] !== 1'b0) begin errors++; $display("FAIL cmp1_fall got %b exp 0", mtip[1]); end
    endtask

    task automatic test_bytesel();
        logic [31:0] r; logic ak, er;
        bus(1'b1, BASE + 32'h0, 32'h5555_55AA, 4'b0001, r, ak, er);
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, r, ak, er);
        checks++; if (r[7:0] !== 8'hAB) begin errors++; $display("FAIL bytesel_lo got %h exp ab", r[7:0]); end
        checks++; if (r !== ms.dat) begin errors++; $display("FAIL bytesel_model got %h exp %h", r, ms.dat); end
    endtask

    task automatic test_errors();
        logic [31:0] r; logic ak, er;
        bus(1'b1, BASE + 32'(16 + 8 * NC), 32'hDEAD_BEEF, 4'hF, r, ak, er);
        checks++; if (er !== 1'b1 || ak !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL err_end got err=%b ack=%b dat=%h exp 1 0 0", er, ak, r); end
        bus(1'b0, BASE + 32'h2, 32'h0, 4'hF, r, ak, er);
        checks++; if (er !== 1'b1 || ak !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL err_misalign got err=%b ack=%b dat=%h exp 1 0 0", er, ak, r); end
        @(negedge clk);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b exp 0", err_o); end
        bus(1'b1, BASE + 32'h2, 32'h0, 4'hF, r, ak, er);
        bus(1'b0, BASE - 32'h4, 32'h0, 4'hF, r, ak, er);
        checks++; if (er !== 1'b1 || ak !== 1'b0) begin errors++; $display("FAIL err_below got err=%b ack=%b exp 1 0", er, ak); end
        bus(1'b0, BASE + 32'h18, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'd100) begin errors++; $display("FAIL err_nochange_cmp got %h exp 64", r); end
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== ms.dat) begin errors++; $display("FAIL err_nochange_mtime got %h exp %h", r, ms.dat); end
    endtask

    task automatic test_random();
        logic [31:0] r, a, d; logic ak, er, w;
        int k;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 15);
            if (k < 8)        a = BASE + 32'(4 * k);
            else if (k == 8)  a = BASE + 32'(16 + 8 * NC);
            else if (k == 9)  a = BASE + 32'($urandom_range(1, 3));
            else if (k == 10) a = BASE - 32'h4;
            else              a = BASE + 32'(4 * $urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == BASE + 32'hC) d = d & 32'h7;
            if (a == BASE + 32'h8) d = d | 32'h1;
            bus(w, a, d, 4'($urandom_range(0, 15)), r, ak, er);
            checks++;
            if (ak !== ms.ack || er !== ms.err || r !== ms.dat || mtip !== model_mtip()) begin
                errors++;
                $display("FAIL rand_txn%0d got ack=%b err=%b dat=%h mtip=%b exp %b %b %h %b",
                         i, ak, er, r, mtip, ms.ack, ms.err, ms.dat, model_mtip());
            end
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] r; logic ak, er;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL midreset_resp got ack=%b err=%b dat=%h exp 0 0 0", ack_o, err_o, dat_o); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mtip !== '0) begin errors++; $display("FAIL midreset_mtip got %b exp 0", mtip); end
        bus(1'b0, BASE + 32'h8, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL midreset_ctrl got %h exp 1", r); end
        bus(1'b0, BASE + 32'hC, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_pre got %h exp 0", r); end
        bus(1'b0, BASE + 32'h1C, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_cmp1hi got %h exp ffffffff", r); end
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_shadow got %h exp 0", r); end
        bus(1'b0, BASE + 32'h0, 32'h0, 4'hF, r, ak, er);
        checks++; if (r !== ms.dat || r > 32'd20) begin errors++; $display("FAIL midreset_mtime got %h exp %h", r, ms.dat); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_prescale();
        test_carry();
        test_compare();
        test_bytesel();
        test_errors();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint_timer_wb.md
# clint_timer_wb

Parametrised machine-timer peripheral on the Wishbone data bus: one free-running 64-bit mtime counter with programmable prescaler and enable, plus NUM_CMP independent 64-bit mtimecmp comparators each driving its own timer-interrupt line. It replaces the single-comparator mtime register block for multi-hart / multi-event configurations. It adds several features that block lacks:
- atomic 64-bit mtime reads through a shadow latch
- registered Wishbone responses
- error response on unmapped accesses

## Interface
Parameters:
- BASE_ADR, 32'h0000_2000, byte address of register offset 0; must be 8-byte aligned
- NUM_CMP, 2, number of comparators / interrupt lines, 1..8
- PRESCALE_W, 8, width of prescaler register

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables; sel[k] covers dat[8k+7:8k]
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  registered acknowledge
- wb_err_o  out  1  registered error (unmapped or misaligned)
- wb_stall_o  out  1  tied 0
- mtip_o  out  NUM_CMP  per-comparator timer interrupt, level

## Operation
Register map, offset = wb_adr_i - BASE_ADR, word-aligned:
- 0x00 MTIME_LO: mtime[31:0]. A read also latches mtime[63:32] into the shadow register.
- 0x04 MTIME_HI: a read returns the shadow register; a write updates mtime[63:32].
- 0x08 CTRL: bit0 EN, reset 1. Other bits read 0; writes to them are ignored.
- 0x0C PRESCALE: [PRESCALE_W-1:0], reset 0. Upper bits read 0.
- 0x10+8n / 0x14+8n MTIMECMP[n] LO / HI, n = 0..NUM_CMP-1. Reset value is all ones.

Access rules:
- All writes honour wb_sel_i byte-wise.
- An access to any offset ≥ 0x10+8·NUM_CMP, any offset below BASE_ADR, or any address with wb_adr_i[1:0]≠0 gets a wb_err_o response instead of ack. Writes are discarded and wb_dat_o = 0.

Counter:
- Prescaler counter pcnt is PRESCALE_W bits.
- When EN=1: if pcnt == PRESCALE, then tick (pcnt←0, mtime←mtime+1); otherwise pcnt←pcnt+1.
- When EN=0: pcnt and mtime hold.
- The increment is full 64-bit with carry. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- A write to PRESCALE or CTRL clears pcnt to 0.
- A write to MTIME_LO or MTIME_HI suppresses that cycle's tick entirely. Written bytes take the bus data, unwritten bytes hold, and pcnt is cleared.

Interrupts:
- mtip_o[n] = (mtime ≥ mtimecmp[n]), unsigned 64-bit comparison.
- Computed combinationally from registered state only; no path from bus inputs.

## Timing
- Accept: a request is accepted at the rising edge where wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o. Back-to-back accesses therefore take 2 cycles each.
- Writes take effect at the accept edge.
- ack or err is asserted for exactly one cycle, starting the cycle after acceptance. wb_dat_o is valid in that same cycle and holds the value sampled at the accept edge (pre-tick mtime).
- Read/write in the same cycle as a tick: the read returns the pre-tick value. The shadow latch captures the same pre-tick mtime[63:32] as the LO word returned.
- Comparator latency: mtip_o reflects a new mtime or mtimecmp value in the cycle after the edge that updates it.
- Reset (assert, any time including mid-transaction):
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0
  - mtime = 0, pcnt = 0, shadow = 0, EN = 1, PRESCALE = 0
  - every mtimecmp = all ones, so mtip_o = 0
  - Any in-flight request is dropped with no response.
- Reset release: the first tick occurs at the first rising edge with wb_rst_i low.
- Dropping wb_cyc_i during the response cycle does not cancel a write that was already accepted.

## Test plan
- Reset, then idle 10 cycles with PRESCALE=0 -> MTIME_LO reads 10 (±the read-path cycle, checked exactly against the model); mtip_o = 0.
- Write PRESCALE=3, observe 40 cycles -> mtime advances exactly 10. Write CTRL=0 -> mtime frozen across 20 cycles.
- Write MTIME_HI=0, MTIME_LO=32'hFFFF_FFFE. Read LO, then wait 5 cycles and read HI -> HI returns 0 (shadow), and a fresh LO read shows the carry into HI=1.
- Write MTIMECMP[1]=64'd100, MTIMECMP[0] left at all ones. Run mtime from 0 -> mtip_o[1] rises in the cycle after mtime becomes 100; mtip_o[0] stays 0. Rewrite CMP[1] HI=1 -> mtip_o[1] falls.
- Write MTIME_LO with sel=4'b0001, data 8'hAA, coincident with a tick -> mtime[7:0]=8'hAA, other bytes unchanged, no increment that cycle.
- Access offset 0x10+8·NUM_CMP and address BASE_ADR+2 -> wb_err_o for one cycle, no ack, no state change. Assert wb_rst_i mid-read -> no ack; all reset values hold.
